// File: rtl/fir_cfg_master.sv
// ----------------------------------------------------------------------------
// fir_cfg_master
//
// AXI4-Lite initiator that programs and launches the FIR accelerator through
// its AXI-Lite slave port. A cfg_start pulse in IDLE starts this sequence:
//   1. write data_length (0x10)
//   2. write every tap coefficient (0x20 + 4*i, i = 0..Tape_Num-1)
//   3. write ap_start (0x00 <= 1)
//   4. poll ap_ctrl (0x00) until ap_done (bit1) is seen, or until pPOLL_MAX
//      reads have been made, whichever comes first
// At the end, done pulses for one cycle. timeout is valid with done.
//
// Ports
//   axis_clk, axis_rst_n      clock, asynchronous active-low reset
//   cfg_start                 one-cycle start request (used only in IDLE)
//   data_len                  data_length value, latched on accepted start
//   coef_idx / coef_data      coefficient lookup. coef_data must be a
//                             combinational function of coef_idx.
//   busy, done, timeout       sequence status. timeout holds until next start.
//   status                    last rdata read from ap_ctrl
//   aw*/w*/ar*/r*             AXI4-Lite master channels (no B channel on the
//                             FIR slave port)
//
// coef_idx runs one beat ahead of the tap being written: when a tap beat
// starts, its wdata register already captures coef_data. This lets the tap
// beats run back-to-back with a registered lookup index. coef_idx saturates
// at Tape_Num-1.
// ----------------------------------------------------------------------------
module fir_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int pPOLL_MAX   = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,

    input  logic                   cfg_start,
    input  logic [pDATA_WIDTH-1:0] data_len,
    output logic [7:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_data,

    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [pDATA_WIDTH-1:0] status,

    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,

    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    output logic                   rready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata
);

    localparam int POLL_W = $clog2(pPOLL_MAX + 1);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
    localparam logic [pDATA_WIDTH-1:0] AP_START  = pDATA_WIDTH'(32'h1);
    localparam logic [7:0]             LAST_TAP  = 8'(Tape_Num - 1);
    localparam logic [POLL_W-1:0]      LAST_POLL = POLL_W'(pPOLL_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_TAP,
        S_WR_START,
        S_RD,
        S_DONE
    } state_e;

    state_e                   state_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     aw_done_q;
    logic                     w_done_q;
    logic [pADDR_WIDTH-1:0]   awaddr_q;
    logic [pDATA_WIDTH-1:0]   wdata_q;
    logic                     arvalid_q;
    logic                     rready_q;
    logic [pDATA_WIDTH-1:0]   status_q;
    logic [7:0]               tap_q;
    logic [7:0]               coef_idx_q;
    logic [POLL_W-1:0]        poll_cnt_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     timeout_q;

    // Handshake terms and next-value helpers
    logic       aw_hs;
    logic       w_hs;
    logic       aw_fin;
    logic       w_fin;
    logic       beat_end;
    logic       ar_hs;
    logic       r_hs;
    logic [7:0] tap_d;
    logic [7:0] coef_idx_d;

    assign aw_hs    = awvalid_q && awready;
    assign w_hs     = wvalid_q && wready;
    // A channel is finished if it completed earlier in this beat or
    // completes now. This covers both channels finishing in the same cycle.
    assign aw_fin   = aw_done_q || aw_hs;
    assign w_fin    = w_done_q || w_hs;
    assign beat_end = aw_fin && w_fin;
    assign ar_hs    = arvalid_q && arready;
    assign r_hs     = rready_q && rvalid;

    assign tap_d      = tap_q + 8'd1;
    assign coef_idx_d = (coef_idx_q == LAST_TAP) ? coef_idx_q : coef_idx_q + 8'd1;

    function automatic logic [pADDR_WIDTH-1:0] tap_addr(input logic [7:0] idx);
        return pADDR_WIDTH'(32'h20 + {22'd0, idx, 2'b00});
    endfunction

    // NOTE: the asynchronous reset clears every valid at once. A reset in the
    // middle of a beat abandons that transaction; it is never resumed.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            status_q   <= '0;
            tap_q      <= '0;
            coef_idx_q <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. When a later
            // assignment to the same register appears below (for example, a
            // valid re-raised for the next beat), it takes precedence over
            // the earlier drop.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_q    <= S_WR_LEN;
                        busy_q     <= 1'b1;
                        timeout_q  <= 1'b0;
                        tap_q      <= '0;
                        coef_idx_q <= '0;
                        poll_cnt_q <= '0;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        awaddr_q   <= ADDR_LEN;
                        wdata_q    <= data_len;
                    end
                end

                S_WR_LEN, S_WR_TAP, S_WR_START: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;

                    if (!beat_end) begin
                        aw_done_q <= aw_fin;
                        w_done_q  <= w_fin;
                    end else begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        case (state_q)
                            S_WR_LEN: begin
                                // coef_idx is 0 here, so coef_data is tap 0.
                                state_q    <= S_WR_TAP;
                                awvalid_q  <= 1'b1;
                                wvalid_q   <= 1'b1;
                                awaddr_q   <= tap_addr(tap_q);
                                wdata_q    <= coef_data;
                                coef_idx_q <= coef_idx_d;
                            end
                            S_WR_TAP: begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                if (tap_q == LAST_TAP) begin
                                    state_q  <= S_WR_START;
                                    awaddr_q <= ADDR_CTRL;
                                    wdata_q  <= AP_START;
                                end else begin
                                    // coef_idx already equals tap_q+1.
                                    tap_q      <= tap_d;
                                    awaddr_q   <= tap_addr(tap_d);
                                    wdata_q    <= coef_data;
                                    coef_idx_q <= coef_idx_d;
                                end
                            end
                            default: begin
                                // S_WR_START finished: issue the first poll.
                                state_q   <= S_RD;
                                arvalid_q <= 1'b1;
                                rready_q  <= 1'b1;
                            end
                        endcase
                    end
                end

                S_RD: begin
                    if (ar_hs) arvalid_q <= 1'b0;

                    if (r_hs) begin
                        rready_q   <= 1'b0;
                        status_q   <= rdata;
                        poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                        if (rdata[1]) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b0;
                        end else if (poll_cnt_q == LAST_POLL) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end else if (!arvalid_q && !rready_q) begin
                        // The previous read has completed and the one idle
                        // cycle has passed, so start the next poll.
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign coef_idx = coef_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign status   = status_q;
    assign awvalid  = awvalid_q;
    assign awaddr   = awaddr_q;
    assign wvalid   = wvalid_q;
    assign wdata    = wdata_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    // Every poll targets ap_ctrl, so the read address is a constant.
    assign araddr   = ADDR_CTRL;

endmodule

// File: tb/tb_fir_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_fir_cfg_master
//
// Directed and randomized stimulus for fir_cfg_master. The bench provides:
//   - a reactive AXI4-Lite slave with configurable ready/response latencies
//   - a coefficient lookup driven from coef_idx
//   - a reference model for the sequence: the expected write list, and the
//     expected number of polls, final status and timeout derived from the
//     response list.
// ----------------------------------------------------------------------------
module tb_fir_cfg_master;

    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int TAPS     = 11;
    localparam int POLL_MAX = 4;

    logic          axis_clk   = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          cfg_start  = 1'b0;
    logic [DW-1:0] data_len   = '0;
    logic [7:0]    coef_idx;
    logic [DW-1:0] coef_data;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [DW-1:0] status;
    logic          awvalid;
    logic [AW-1:0] awaddr;
    logic          awready    = 1'b0;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready     = 1'b0;
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          arready    = 1'b0;
    logic          rready;
    logic          rvalid     = 1'b0;
    logic [DW-1:0] rdata      = '0;

    fir_cfg_master #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (TAPS),
        .pPOLL_MAX   (POLL_MAX)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cfg_start  (cfg_start),
        .data_len   (data_len),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .status     (status),
        .awvalid    (awvalid),
        .awaddr     (awaddr),
        .awready    (awready),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .wready     (wready),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .rready     (rready),
        .rvalid     (rvalid),
        .rdata      (rdata)
    );

    always #5 axis_clk = ~axis_clk;

    // ---------------- coefficient source ----------------
    logic [31:0] coef_seed = '0;   // 0 selects the idx*3-5 table
    assign coef_data = (coef_seed == 32'd0) ? ({24'd0, coef_idx} * 32'd3 - 32'd5)
                                            : (coef_seed ^ ({24'd0, coef_idx} * 32'h9E3779B9));

    function automatic logic [31:0] ref_coef(input int i);
        if (coef_seed == 32'd0) return 32'(i * 3 - 5);
        return coef_seed ^ (32'(i) * 32'h9E3779B9);
    endfunction

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reactive AXI-Lite slave ----------------
    int          mode      = 0;    // 0 always ready, 1 tap-4 wready skew, 2 random
    int          r_lat_cfg = 0;    // read data latency after arready, -1 = random
    logic [31:0] resp_q[$];
    logic [31:0] dflt_resp = '0;

    int cyc = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
    int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    bit r_pending = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [AW-1:0] aw_prev;
    logic [DW-1:0] w_prev;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    int aw_cyc[$], w_cyc[$], ar_cyc[$], r_cyc[$];
    int done_cnt  = 0;
    int done_cyc  = 0;
    int proto_err = 0;

    function automatic int pick_lat(input logic [AW-1:0] addr, input bit is_w);
        if (mode == 1) return (is_w && addr == AW'(12'h030)) ? 2 : 0;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    // Every decision is made at the negedge, so each handshake recorded here
    // takes place at the following posedge.
    always @(negedge axis_clk) begin
        cyc++;
        if (!axis_rst_n) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
            r_pending = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
        end else begin
            // Once a valid is raised, it must stay up with stable payload
            // until its handshake completes.
            if (aw_pend && (!awvalid || awaddr !== aw_prev)) proto_err++;
            if (w_pend && (!wvalid || wdata !== w_prev)) proto_err++;
            if (ar_pend && !arvalid) proto_err++;
            // While read data is outstanding: arvalid low, rready held high.
            if (r_pending && (arvalid || !rready)) proto_err++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) proto_err++;
            end

            if (awvalid) begin
                if (aw_wait == 0) aw_lat = pick_lat(awaddr, 1'b0);
                awready = (aw_wait >= aw_lat);
                if (awready) begin
                    aw_log.push_back(32'(awaddr)); aw_cyc.push_back(cyc); aw_wait = 0;
                end else aw_wait++;
            end else begin
                awready = 1'b0; aw_wait = 0;
            end

            if (wvalid) begin
                if (w_wait == 0) w_lat = pick_lat(awaddr, 1'b1);
                wready = (w_wait >= w_lat);
                if (wready) begin
                    w_log.push_back(wdata); w_cyc.push_back(cyc); w_wait = 0;
                end else w_wait++;
            end else begin
                wready = 1'b0; w_wait = 0;
            end

            if (arvalid) begin
                if (ar_wait == 0) ar_lat = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
                arready = (ar_wait >= ar_lat);
                if (arready) begin
                    ar_cyc.push_back(cyc); ar_wait = 0;
                    r_pending = 1; r_wait = 0;
                    r_lat = (r_lat_cfg >= 0) ? r_lat_cfg : int'($urandom_range(0, 3));
                end else ar_wait++;
            end else begin
                arready = 1'b0; ar_wait = 0;
            end

            if (r_pending && r_wait >= r_lat) begin
                rvalid = 1'b1;
                rdata  = (resp_q.size() > 0) ? resp_q[0] : dflt_resp;
                if (rready) begin
                    if (resp_q.size() > 0) void'(resp_q.pop_front());
                    r_cyc.push_back(cyc); r_pending = 0;
                end
            end else begin
                rvalid = 1'b0;
                rdata  = 32'hFFFF_FFFF;  // junk that also has ap_done set
                if (r_pending) r_wait++;
            end

            aw_pend = awvalid && !awready; aw_prev = awaddr;
            w_pend  = wvalid && !wready;   w_prev  = wdata;
            ar_pend = arvalid && !arready;
        end
    end

    // ---------------- reference model for the poll phase ----------------
    function automatic void model_reads(input logic [31:0] rsp[$], input logic [31:0] dflt,
                                        output int n, output logic to, output logic [31:0] st);
        logic [31:0] r;
        n = 0; to = 1'b0; st = '0;
        for (int i = 0; i < POLL_MAX; i++) begin
            r  = (i < rsp.size()) ? rsp[i] : dflt;
            n  = i + 1;
            st = r;
            if (r[1]) return;
        end
        to = 1'b1;
    endfunction

    // Runs one full sequence using the responses already in resp_q. If
    // repulse_at > 0, cfg_start is pulsed again that many cycles in.
    task automatic run_seq(input string tag, input logic [31:0] len, input int repulse_at,
                           input bit timed);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] rsp_copy[$];
        int          exp_reads;
        logic        exp_to;
        logic [31:0] exp_st;
        int          start_cyc, done_before, n;

        exp_a.push_back(32'h10); exp_d.push_back(len);
        for (int i = 0; i < TAPS; i++) begin
            exp_a.push_back(32'h20 + 32'(4 * i)); exp_d.push_back(ref_coef(i));
        end
        exp_a.push_back(32'h00); exp_d.push_back(32'h1);
        rsp_copy = resp_q;
        model_reads(rsp_copy, dflt_resp, exp_reads, exp_to, exp_st);

        aw_log.delete(); w_log.delete();
        aw_cyc.delete(); w_cyc.delete(); ar_cyc.delete(); r_cyc.delete();
        done_before = done_cnt;

        @(negedge axis_clk); #1;
        data_len = len; cfg_start = 1'b1; start_cyc = cyc;
        @(negedge axis_clk); #1;
        cfg_start = 1'b0; data_len = ~len;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_timeout_clr"}, 32'(timeout), 32'd0);

        n = 0;
        while (done_cnt == done_before && n < 3000) begin
            @(negedge axis_clk); #1;
            n++;
            cfg_start = (n == repulse_at);
        end
        cfg_start = 1'b0;
        check({tag, "_done_once"}, 32'(done_cnt - done_before), 32'd1);

        check({tag, "_aw_count"}, 32'(aw_log.size()), 32'(exp_a.size()));
        check({tag, "_w_count"}, 32'(w_log.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < aw_log.size()) check($sformatf("%s_awaddr%0d", tag, i), aw_log[i], exp_a[i]);
            if (i < w_log.size())  check($sformatf("%s_wdata%0d", tag, i), w_log[i], exp_d[i]);
        end
        check({tag, "_reads"}, 32'(r_cyc.size()), 32'(exp_reads));
        check({tag, "_ar_count"}, 32'(ar_cyc.size()), 32'(exp_reads));
        check({tag, "_status"}, status, exp_st);
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (r_cyc.size() > 0)
            check({tag, "_done_lat"}, 32'(done_cyc - r_cyc[r_cyc.size()-1]), 32'd1);

        if (timed) begin
            if (aw_cyc.size() > 0) check({tag, "_first_aw"}, 32'(aw_cyc[0] - start_cyc), 32'd1);
            for (int i = 0; i < w_cyc.size(); i++)
                check($sformatf("%s_wcyc%0d", tag, i), 32'(w_cyc[i] - start_cyc), 32'(i + 1));
            if (ar_cyc.size() > 0 && w_cyc.size() > 0)
                check({tag, "_first_ar"}, 32'(ar_cyc[0] - w_cyc[w_cyc.size()-1]), 32'd1);
            for (int i = 1; i < ar_cyc.size(); i++)
                check($sformatf("%s_argap%0d", tag, i), 32'(ar_cyc[i] - ar_cyc[i-1]), 32'd2);
        end

        @(negedge axis_clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_timeout_hold"}, 32'(timeout), 32'(exp_to));
        check({tag, "_proto"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit found;

        // ---- reset state ----
        #1;
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_coef_idx", 32'(coef_idx), 32'd0);
        check("rst_awaddr", 32'(awaddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        repeat (2) @(negedge axis_clk);
        #1 axis_rst_n = 1'b1;

        // ---- always-ready slave, idx*3-5 coefficients, 0x4 then 0x6 ----
        mode = 0; r_lat_cfg = 0; coef_seed = '0; dflt_resp = '0;
        resp_q.delete(); resp_q.push_back(32'h4); resp_q.push_back(32'h6);
        run_seq("basic", 32'd600, 0, 1'b1);

        // ---- awready two cycles ahead of wready on tap 4 ----
        mode = 1; coef_seed = 32'hA5A5_0001;
        resp_q.delete(); resp_q.push_back(32'h6);
        run_seq("skew", 32'd123, 0, 1'b0);

        // ---- read data three cycles after arready ----
        mode = 0; r_lat_cfg = 3; coef_seed = '0;
        resp_q.delete(); resp_q.push_back(32'h0); resp_q.push_back(32'h2);
        run_seq("rlat", 32'd77, 0, 1'b0);

        // ---- ap_done never set: poll limit ----
        r_lat_cfg = 0; dflt_resp = '0; resp_q.delete();
        run_seq("tmo", 32'd5, 0, 1'b1);

        // ---- cfg_start re-pulsed during tap writes ----
        resp_q.delete(); resp_q.push_back(32'h2);
        run_seq("repulse", 32'd42, 5, 1'b1);
        repeat (10) @(negedge axis_clk);
        #1;
        check("repulse_no_restart", 32'(aw_log.size()), 32'(TAPS + 2));
        check("repulse_idle", 32'(busy), 32'd0);

        // ---- reset while tap 7 is being written ----
        @(negedge axis_clk); #1;
        data_len = 32'd999; cfg_start = 1'b1;
        @(negedge axis_clk); #1;
        cfg_start = 1'b0;
        found = 0; k = 0;
        while (!found && k < 100) begin
            @(negedge axis_clk); #1;
            k++;
            found = awvalid && (awaddr == AW'(12'h03C));
        end
        check("rst7_reached", 32'(found), 32'd1);
        axis_rst_n = 1'b0;
        #1;
        check("rst7_awvalid", 32'(awvalid), 32'd0);
        check("rst7_wvalid", 32'(wvalid), 32'd0);
        check("rst7_arvalid", 32'(arvalid), 32'd0);
        check("rst7_busy", 32'(busy), 32'd0);
        check("rst7_coef_idx", 32'(coef_idx), 32'd0);
        @(negedge axis_clk);
        @(negedge axis_clk); #1;
        axis_rst_n = 1'b1;
        resp_q.delete(); resp_q.push_back(32'h6);
        run_seq("restart", 32'd31, 0, 1'b1);

        // ---- randomized latencies, coefficients and responses ----
        for (int it = 0; it < 6; it++) begin
            mode = 2; r_lat_cfg = -1;
            coef_seed = $urandom | 32'h1;
            resp_q.delete();
            k = int'($urandom_range(0, 5));
            for (int j = 0; j < k; j++) resp_q.push_back($urandom & ~32'h2);
            if ($urandom_range(0, 1) == 1) resp_q.push_back($urandom | 32'h2);
            dflt_resp = ($urandom_range(0, 1) == 1) ? 32'h2 : 32'h0;
            run_seq($sformatf("rand%0d", it), $urandom, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
